mem_interface_unit: RTL and testbench
=====================================

# mem_interface_unit

Memory interface unit between the instruction unit and byte-wide main memory. Accepts load/store commands (14-bit address, 16-bit result), runs a request/acknowledge handshake with main memory, returns the loaded byte, and signals completion with a one-cycle `mem_done` pulse. Stores write the 16-bit ALU result as two consecutive bytes, little-endian.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a memory request may wait for `mem_ack` before it is aborted. Used only with `MIU_TIMEOUT_EN`. Range 1..255.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  reset, synchronous, active-low
- `load`  in  1  load command level from the instruction unit
- `store`  in  1  store command level from the instruction unit
- `addr`  in  14  command byte address
- `result`  in  16  store data
- `data`  out  8  last loaded byte, registered
- `mem_done`  out  1  one-cycle completion pulse
- `mem_err`  out  1  one-cycle pulse with `mem_done` when a request times out
- `busy`  out  1  high in every state except IDLE
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high
- `mem_addr`  out  14  memory address
- `mem_wdata`  out  8  write byte
- `mem_rdata`  in  8  read byte; valid in the cycle `mem_ack` is high
- `mem_ack`  in  1  one-cycle acknowledge; counted only while `mem_req` is high

## Operation
- States: IDLE, RD, WR_LO, WR_HI, DONE.
- IDLE:
  - `load`=1 → latch `addr` → RD.
  - Otherwise `store`=1 → latch `addr` and `result` → WR_LO.
  - Load has priority when both are high; the store is dropped.
- RD: `mem_req`=1, `mem_we`=0, `mem_addr`=latched address. On `mem_ack`: `data` ← `mem_rdata`, go to DONE.
- WR_LO: `mem_req`=1, `mem_we`=1, `mem_wdata`=`result[7:0]`, `mem_addr`=A. On `mem_ack` → WR_HI.
- WR_HI: same as WR_LO with `mem_wdata`=`result[15:8]` and `mem_addr`=(A+1) mod 2^14, so 0x3FFF wraps to 0x0000. On `mem_ack` → DONE.
- DONE: `mem_done`=1 for exactly one cycle, `mem_req`=0, then → IDLE.
  - A command level still high in IDLE is accepted again. The instruction unit drops `load`/`store` on `mem_done`.
- `addr`/`result` changes after acceptance are ignored.
- `data` holds its value until the next successful load. Stores and aborted loads leave it unchanged.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset (all outputs registered): state IDLE, `data`=0x00, `mem_done`=0, `mem_err`=0, `busy`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, timeout counter=0.
- Reset asserted mid-transaction takes effect at the next edge: `mem_req` drops immediately, no `mem_done` is issued, and a partial store is not completed.

## Timing
- Cycle 0: IDLE samples the command. Cycle 1: `mem_req` high.
- Minimum load latency: ack in cycle 1 → `mem_done` and new `data` in cycle 2, i.e. 2 cycles from command to `mem_done`.
- Minimum store latency: acks in cycles 1 and 2 → `mem_done` in cycle 3.
- Each ack cycle of wait state adds one cycle.
- `mem_req` stays continuously high across WR_LO→WR_HI when ack timing allows. `mem_addr`/`mem_wdata` change on the edge after the low-byte ack.
- Earliest new command is accepted in the cycle after DONE, so two back-to-back loads complete every 3 cycles minimum.

## Configuration
- Macro: `MIU_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to each of RD/WR_LO/WR_HI and increments each cycle without `mem_ack`.
  - When it reaches `TIMEOUT_CYCLES`, `mem_req` drops and the unit goes to DONE with `mem_done`=1 and `mem_err`=1.
  - A timeout in WR_LO skips the high byte.
  - An ack in the same cycle the count is reached wins, and no error is raised.
- Not defined: the unit waits indefinitely for `mem_ack`, `mem_err` is constant 0, and no counter is built.

## Test plan
- Reset mid-store: reset_n=0 during WR_HI → next cycle `mem_req`=0, state IDLE, no `mem_done`, `data` unchanged from pre-reset (0x00 after reset).
- Load: `addr`=0x0123, `load`=1, ack in cycle 1 with `mem_rdata`=0xA5 → `mem_done` in cycle 2, `data`=0xA5, `mem_we`=0 throughout.
- Store with wrap: `addr`=0x3FFF, `result`=0xBEEF, immediate acks → two writes, (0x3FFF, 0xEF) then (0x0000, 0xBE); `mem_done` in cycle 3; `data` unchanged.
- Priority and wait states: `load`=`store`=1, `addr`=0x0010, ack delayed 4 cycles → exactly one read at 0x0010, no write, `mem_done` in cycle 6.
- Timeout (`MIU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): load with no ack → `mem_req` low after 8 request cycles, `mem_done`=`mem_err`=1 for one cycle. Without the macro the same stimulus keeps `mem_req` high for 100+ cycles with `mem_err`=0.

Source files
------------

// File: rtl/mem_interface_unit_if.sv
// -----------------------------------------------------------------------------
// mem_interface_unit_if
//
// Bundles the instruction-unit command signals and the byte-wide main-memory
// bus of mem_interface_unit.
//
// Modports
//   master : the memory interface unit itself. It takes commands and drives
//            the memory request bus.
//   slave  : the environment, meaning the instruction unit plus main memory.
//
// Handshake
//   A command level (load or store) is sampled only while the unit is idle.
//   mem_req stays high, with mem_we/mem_addr/mem_wdata stable, until a cycle
//   in which mem_ack is high; that cycle completes the byte transfer, and
//   mem_rdata is valid in that same cycle. mem_ack seen while mem_req is low
//   is ignored. Completion of a whole command is a one-cycle mem_done pulse;
//   the instruction unit drops its command level on seeing it.
// -----------------------------------------------------------------------------
interface mem_interface_unit_if;
   logic        load;
   logic        store;
   logic [13:0] addr;
   logic [15:0] result;
   logic [7:0]  data;
   logic        mem_done;
   logic        mem_err;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport master (
      input  load, store, addr, result, mem_rdata, mem_ack,
      output data, mem_done, mem_err, busy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output load, store, addr, result, mem_rdata, mem_ack,
      input  data, mem_done, mem_err, busy, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_interface_unit.sv
// -----------------------------------------------------------------------------
// mem_interface_unit
//
// Sits between the instruction unit and byte-wide main memory. A load reads
// one byte into the registered data output. A store writes the 16-bit result
// as two bytes, little-endian: the low byte goes to A and the high byte goes
// to (A+1) mod 2^14. Every command ends with a one-cycle mem_done pulse.
// Every output is registered.
//
// Parameters
//   TIMEOUT_CYCLES : request cycles to wait for mem_ack before aborting
//                    (1..255). Used only when MIU_TIMEOUT_EN is defined.
//
// Optional feature
//   MIU_TIMEOUT_EN : when defined, a per-byte wait counter aborts a request
//                    that goes unacknowledged. The abort finishes the command
//                    with mem_done and mem_err both high. When the macro is
//                    undefined the unit waits forever, mem_err is tied low
//                    and no counter is built.
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : synchronous, active-low reset
//   bus      : command and memory bus (mem_interface_unit_if.master)
//   state_o  : current FSM state, for debug
// -----------------------------------------------------------------------------
module mem_interface_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   mem_interface_unit_if.master bus,
   output logic [2:0]           state_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD    = 3'd1;
   localparam logic [2:0] S_WR_LO = 3'd2;
   localparam logic [2:0] S_WR_HI = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_interface_unit: TIMEOUT_CYCLES must be in 1..255");
   end

   logic [2:0]  state_q, state_d;
   logic [7:0]  hi_q, hi_d;          // high store byte, kept for WR_HI
   logic [7:0]  data_q, data_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [13:0] maddr_q, maddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        ack_v;

   // An acknowledge counts only while a request is actually outstanding.
   assign ack_v = bus.mem_ack & req_q;

`ifdef MIU_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       to_hit;
   logic       in_req;

   // The counter holds the number of unacknowledged cycles already spent in
   // the current request state. The abort fires in the last permitted cycle.
   assign to_hit = (cnt_q == TO_LAST);
   assign in_req = (state_q == S_RD) || (state_q == S_WR_LO) || (state_q == S_WR_HI);

   // Staying in a request state means no ack arrived, so the counter counts.
   // Any state change (entering the next byte, DONE, ...) clears it.
   always_comb begin
      cnt_d = 8'd0;
      if (in_req && (state_d == state_q)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.mem_err = err_q;
`else
   assign bus.mem_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      data_d  = data_q;
      done_d  = 1'b0;
      req_d   = req_q;
      we_d    = we_q;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
`ifdef MIU_TIMEOUT_EN
      err_d   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            // Load wins over a simultaneous store; that store is dropped.
            if (bus.load) begin
               state_d = S_RD;
               req_d   = 1'b1;
               we_d    = 1'b0;
               maddr_d = bus.addr;
            end else if (bus.store) begin
               state_d = S_WR_LO;
               req_d   = 1'b1;
               we_d    = 1'b1;
               maddr_d = bus.addr;
               wdata_d = bus.result[7:0];
               hi_d    = bus.result[15:8];
            end
         end

         S_RD, S_WR_LO, S_WR_HI: begin
            if (ack_v) begin
               case (state_q)
                  S_RD: begin
                     data_d  = bus.mem_rdata;
                     state_d = S_DONE;
                     req_d   = 1'b0;
                     we_d    = 1'b0;
                     done_d  = 1'b1;
                  end
                  S_WR_LO: begin
                     // mem_req stays high; the address wraps at 14 bits.
                     state_d = S_WR_HI;
                     maddr_d = maddr_q + 14'd1;
                     wdata_d = hi_q;
                  end
                  default: begin
                     state_d = S_DONE;
                     req_d   = 1'b0;
                     we_d    = 1'b0;
                     done_d  = 1'b1;
                  end
               endcase
            end
`ifdef MIU_TIMEOUT_EN
            // An ack in the final cycle takes the branch above, so no error.
            else if (to_hit) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
`endif
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         hi_q    <= 8'h00;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         maddr_q <= 14'h0000;
         wdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         data_q  <= data_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         req_q   <= req_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.mem_done  = done_q;
   assign bus.busy      = busy_q;
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_wdata = wdata_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_interface_unit
//
// Commands are driven on the falling edge. For each command, a queue of
// expected per-cycle bus/status records is built from the command timing
// rules: one record per request cycle (ack after d wait cycles), then one
// DONE record. A compare process checks the DUT outputs 1 time unit after
// every rising edge. When the queue is empty it expects an idle unit.
// Directed cases pin the model with literal latencies, addresses and bytes.
// -----------------------------------------------------------------------------
module tb_mem_interface_unit;

   localparam int TO_CYC = 8;
`ifdef MIU_TIMEOUT_EN
   localparam int T = TO_CYC;
`else
   localparam int T = 32'h7fff_ffff;
`endif

   typedef struct packed {
      logic        req;
      logic        we;
      logic [13:0] addr;
      logic [7:0]  wdata;
      logic        done;
      logic        err;
      logic        busy;
      logic [7:0]  data;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] state_o;

   mem_interface_unit_if ifc();

   mem_interface_unit #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc),
      .state_o (state_o)
   );

   always #5 clk = ~clk;

   logic [EXP_W-1:0] exp_q[$];
   logic [21:0]      wlog[$];
   logic [13:0]      rlog[$];
   logic [7:0]       exp_data;
   int               total = 0;
   int               bad = 0;
   int               cyc = 0;
   int               cmd_cyc = 0;
   int               done_cyc = 0;
   int               done_cnt = 0;
   int               err_cnt = 0;
   bit               chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic req, input logic we, input logic [13:0] a,
                               input logic [7:0] wd, input logic done, input logic err,
                               input logic busy, input logic [7:0] d);
      exp_t e;
      e.req = req; e.we = we; e.addr = a; e.wdata = wd;
      e.done = done; e.err = err; e.busy = busy; e.data = d;
      return e;
   endfunction

   // Bus monitor (pre-edge samples), then the per-cycle compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (ifc.mem_req === 1'b1 && ifc.mem_ack === 1'b1) begin
            if (ifc.mem_we === 1'b1) wlog.push_back({ifc.mem_addr, ifc.mem_wdata});
            else                     rlog.push_back(ifc.mem_addr);
         end
         cyc++;
         #1;
         if (ifc.mem_done === 1'b1) begin
            done_cyc = cyc;
            done_cnt++;
         end
         if (ifc.mem_err === 1'b1) err_cnt++;
         if (chk_en) begin
            if (exp_q.size() > 0) e = exp_t'(exp_q.pop_front());
            else e = mk(1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0, exp_data);
            chk("mem_req",  32'(ifc.mem_req),  32'(e.req));
            chk("mem_done", 32'(ifc.mem_done), 32'(e.done));
            chk("mem_err",  32'(ifc.mem_err),  32'(e.err));
            chk("busy",     32'(ifc.busy),     32'(e.busy));
            chk("data",     32'(ifc.data),     32'(e.data));
            if (e.req) begin
               chk("mem_we",   32'(ifc.mem_we),   32'(e.we));
               chk("mem_addr", 32'(ifc.mem_addr), 32'(e.addr));
               if (e.we) chk("mem_wdata", 32'(ifc.mem_wdata), 32'(e.wdata));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         ifc.load = 1'b0;
         ifc.store = 1'b0;
         ifc.mem_ack = 1'($urandom);       // stray acks while idle are ignored
         ifc.mem_rdata = 8'($urandom);
         ifc.addr = 14'($urandom);
      end
   endtask

   // One command. d0/d1: wait cycles before the ack of the first/second byte.
   task automatic run_cmd(input bit do_ld, input bit do_st, input logic [13:0] a,
                          input logic [15:0] r, input int d0, input int d1,
                          input logic [7:0] rd);
      bit acks[$];
      int n;
      bit to;
      @(negedge clk);
      cmd_cyc = cyc;
      ifc.load = do_ld;
      ifc.store = do_st;
      ifc.addr = a;
      ifc.result = r;
      ifc.mem_ack = 1'($urandom);
      ifc.mem_rdata = 8'($urandom);
      if (do_ld) begin
         to = (d0 >= T);
         n = to ? T : d0 + 1;
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 1'b1, exp_data));
            acks.push_back(i == d0);
         end
         if (!to) exp_data = rd;
      end else begin
         to = (d0 >= T);
         n = to ? T : d0 + 1;
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(1'b1, 1'b1, a, r[7:0], 1'b0, 1'b0, 1'b1, exp_data));
            acks.push_back(i == d0);
         end
         if (!to) begin
            to = (d1 >= T);
            n = to ? T : d1 + 1;
            for (int i = 0; i < n; i++) begin
               exp_q.push_back(mk(1'b1, 1'b1, a + 14'd1, r[15:8], 1'b0, 1'b0, 1'b1, exp_data));
               acks.push_back(i == d1);
            end
         end
      end
      exp_q.push_back(mk(1'b0, 1'b0, a, 8'h00, 1'b1, to, 1'b1, exp_data));
      foreach (acks[i]) begin
         @(negedge clk);
         ifc.mem_ack = acks[i];
         ifc.mem_rdata = acks[i] ? rd : 8'($urandom);
         ifc.addr = 14'($urandom);          // post-acceptance changes ignored
         ifc.result = 16'($urandom);
      end
      @(negedge clk);                       // DONE cycle: drop the command
      ifc.load = 1'b0;
      ifc.store = 1'b0;
      ifc.mem_ack = 1'($urandom);
      ifc.mem_rdata = 8'($urandom);
   endtask

   // Store whose high byte is cut short by reset while in WR_HI.
   task automatic reset_mid_store(input logic [13:0] a, input logic [15:0] r);
      @(negedge clk);
      cmd_cyc = cyc;
      ifc.store = 1'b1;
      ifc.addr = a;
      ifc.result = r;
      ifc.mem_ack = 1'b0;
      exp_q.push_back(mk(1'b1, 1'b1, a, r[7:0], 1'b0, 1'b0, 1'b1, exp_data));
      exp_q.push_back(mk(1'b1, 1'b1, a + 14'd1, r[15:8], 1'b0, 1'b0, 1'b1, exp_data));
      @(negedge clk);
      ifc.mem_ack = 1'b1;
      @(negedge clk);
      ifc.mem_ack = 1'b0;
      ifc.store = 1'b0;
      reset_n = 1'b0;
      exp_q.delete();
      exp_data = 8'h00;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int d_prev, n_done, n_err;
      bit [1:0] kind;
      logic [13:0] a;
      reset_n = 1'b0;
      ifc.load = 1'b0;
      ifc.store = 1'b0;
      ifc.addr = 14'h0;
      ifc.result = 16'h0;
      ifc.mem_ack = 1'b0;
      ifc.mem_rdata = 8'h0;
      exp_data = 8'h00;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);
      chk("reset_data", 32'(ifc.data), 32'h00);
      chk("reset_busy", 32'(ifc.busy), 32'h0);

      // Load 0x0123, immediate ack with 0xA5.
      rlog.delete(); wlog.delete();
      run_cmd(1'b1, 1'b0, 14'h0123, 16'h0000, 0, 0, 8'hA5);
      chk("ld_latency", 32'(done_cyc - cmd_cyc), 32'd2);
      chk("ld_data", 32'(ifc.data), 32'hA5);
      chk("ld_reads", 32'(rlog.size()), 32'd1);
      chk("ld_raddr", 32'(rlog[0]), 32'h0123);
      chk("ld_writes", 32'(wlog.size()), 32'd0);

      // Store 0xBEEF at 0x3FFF: high byte wraps to 0x0000.
      idle(1);
      rlog.delete(); wlog.delete();
      run_cmd(1'b0, 1'b1, 14'h3FFF, 16'hBEEF, 0, 0, 8'h00);
      chk("st_latency", 32'(done_cyc - cmd_cyc), 32'd3);
      chk("st_nwrites", 32'(wlog.size()), 32'd2);
      chk("st_write0", 32'(wlog[0]), {10'h0, 14'h3FFF, 8'hEF});
      chk("st_write1", 32'(wlog[1]), {10'h0, 14'h0000, 8'hBE});
      chk("st_data_kept", 32'(ifc.data), 32'hA5);

      // Load and store together at 0x0010, ack delayed 4 cycles.
      idle(1);
      rlog.delete(); wlog.delete();
      run_cmd(1'b1, 1'b1, 14'h0010, 16'h1234, 4, 0, 8'h5A);
      chk("pri_latency", 32'(done_cyc - cmd_cyc), 32'd6);
      chk("pri_reads", 32'(rlog.size()), 32'd1);
      chk("pri_raddr", 32'(rlog[0]), 32'h0010);
      chk("pri_writes", 32'(wlog.size()), 32'd0);

      // Back-to-back loads complete every 3 cycles.
      run_cmd(1'b1, 1'b0, 14'h0100, 16'h0, 0, 0, 8'h11);
      d_prev = done_cyc;
      run_cmd(1'b1, 1'b0, 14'h0101, 16'h0, 0, 0, 8'h22);
      chk("b2b_period", 32'(done_cyc - d_prev), 32'd3);
      chk("b2b_data", 32'(ifc.data), 32'h22);

      // Load that is never acknowledged within 100+ cycles.
      idle(1);
      n_err = err_cnt;
      run_cmd(1'b1, 1'b0, 14'h0200, 16'h0, 110, 0, 8'h77);
`ifdef MIU_TIMEOUT_EN
      chk("to_latency", 32'(done_cyc - cmd_cyc), 32'(TO_CYC + 1));
      chk("to_err", 32'(err_cnt - n_err), 32'd1);
      chk("to_data_kept", 32'(ifc.data), 32'h22);
      // Ack in the last permitted cycle wins: no error.
      idle(1);
      n_err = err_cnt;
      run_cmd(1'b1, 1'b0, 14'h0201, 16'h0, TO_CYC - 1, 0, 8'h33);
      chk("to_edge_latency", 32'(done_cyc - cmd_cyc), 32'(TO_CYC + 1));
      chk("to_edge_err", 32'(err_cnt - n_err), 32'd0);
      // Timeout on the low byte skips the high byte.
      idle(1);
      wlog.delete();
      run_cmd(1'b0, 1'b1, 14'h0300, 16'hCAFE, 20, 0, 8'h00);
      chk("to_st_writes", 32'(wlog.size()), 32'd0);
      chk("to_st_latency", 32'(done_cyc - cmd_cyc), 32'(TO_CYC + 1));
`else
      chk("noto_latency", 32'(done_cyc - cmd_cyc), 32'd112);
      chk("noto_err", 32'(err_cnt - n_err), 32'd0);
      chk("noto_data", 32'(ifc.data), 32'h77);
`endif

      // Reset during WR_HI: low byte written, high byte and mem_done never appear.
      idle(1);
      wlog.delete();
      n_done = done_cnt;
      reset_mid_store(14'h0AB0, 16'h4321);
      idle(4);
      chk("rst_no_done", 32'(done_cnt - n_done), 32'd0);
      chk("rst_nwrites", 32'(wlog.size()), 32'd1);
      chk("rst_write0", 32'(wlog[0]), {10'h0, 14'h0AB0, 8'h21});
      chk("rst_data", 32'(ifc.data), 32'h00);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         kind = 2'($urandom_range(0, 2));
         a = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom);
         run_cmd(kind != 2'd1, kind != 2'd0, a, 16'($urandom),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3)),
                 8'($urandom));
         idle($urandom_range(0, 2));
      end
      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
